// File: rtl/ascii_line_packer_if.sv
// Character-in / write-strobe-out bundle of the ASCII line packer.
// The packer owns the slave side; a character source / memory sink owns the master side.
interface ascii_line_packer_if;
    logic [7:0]  in_char;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        ptr_wr_en;
    logic [7:0]  ptr_line;
    logic [15:0] ptr_addr;
    logic        full;
    logic        done;

    modport master (
        output in_char,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  ptr_wr_en,
        input  ptr_line,
        input  ptr_addr,
        input  full,
        input  done
    );

    modport slave (
        input  in_char,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output ptr_wr_en,
        output ptr_line,
        output ptr_addr,
        output full,
        output done
    );
endinterface

// File: rtl/ascii_line_packer.sv
// Packs NUL-terminated ASCII lines two chars per 16-bit word and logs each line's start address.
// Strobes are registered (one cycle after the accepting edge); in_ready drops for good on full/done.
module ascii_line_packer #(
    parameter int MEM_DEPTH  = 256,
    parameter int LINE_COUNT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    ascii_line_packer_if.slave  bus
);

    localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);
    localparam logic [6:0] LAST_LINE = 7'(LINE_COUNT - 1);

    typedef enum logic [1:0] {
        LINE_START = 2'd0,
        HI         = 2'd1,
        LO         = 2'd2,
        STOP       = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  word_ptr;
    logic [6:0]  line_cnt;
    logic [7:0]  hi_byte;

    logic        accept;
    logic        is_nul;
    logic        emit;
    logic        line_end;
    logic [15:0] word;
    logic        last_word;
    logic        last_line;

    always_comb begin
        accept   = bus.in_valid & bus.in_ready;
        is_nul   = (bus.in_char == 8'h00);
        emit     = 1'b0;
        line_end = 1'b0;
        word     = 16'h0000;
        case (state)
            LINE_START, HI: begin
                // A NUL in the high slot closes the line with an all-zero word.
                emit     = accept & is_nul;
                line_end = accept & is_nul;
                word     = 16'h0000;
            end
            LO: begin
                emit     = accept;
                line_end = accept & is_nul;
                word     = {hi_byte, bus.in_char};
            end
            default: begin
                emit     = 1'b0;
                line_end = 1'b0;
            end
        endcase
        last_word = (word_ptr == LAST_ADDR);
        last_line = (line_cnt == LAST_LINE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LINE_START;
            word_ptr      <= 8'h00;
            line_cnt      <= 7'h00;
            hi_byte       <= 8'h00;
            bus.in_ready  <= 1'b0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= 8'h00;
            bus.wr_data   <= 16'h0000;
            bus.ptr_wr_en <= 1'b0;
            bus.ptr_line  <= 8'h00;
            bus.ptr_addr  <= 16'h0000;
            bus.full      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.wr_en     <= 1'b0;
            bus.ptr_wr_en <= 1'b0;
            bus.in_ready  <= (state != STOP);

            if (accept && state == LINE_START) begin
                bus.ptr_wr_en <= 1'b1;
                bus.ptr_line  <= {2'b00, line_cnt[5:0]};
                bus.ptr_addr  <= {8'h00, word_ptr};
            end

            if (accept) begin
                case (state)
                    LINE_START, HI: begin
                        if (!is_nul) begin
                            hi_byte <= bus.in_char;
                            state   <= LO;
                        end
                    end
                    LO: begin
                        if (!is_nul) begin
                            state <= HI;
                        end
                    end
                    default: state <= STOP;
                endcase
            end

            if (emit) begin
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= word_ptr;
                bus.wr_data <= word;
                if (!last_word) begin
                    word_ptr <= word_ptr + 8'd1;
                end
            end

            if (line_end) begin
                line_cnt <= line_cnt + 7'd1;
                state    <= LINE_START;
            end

            // Stop conditions override the normal next state; both may fire on one word.
            if (emit && last_word) begin
                bus.full <= 1'b1;
            end
            if (line_end && last_line) begin
                bus.done <= 1'b1;
            end
            if ((emit && last_word) || (line_end && last_line)) begin
                state        <= STOP;
                bus.in_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ascii_line_packer.sv
// Self-checking bench for ascii_line_packer: vector table, hand sequences, randomized lines vs a packing model.
module tb_ascii_line_packer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ascii_line_packer_if bus ();

    ascii_line_packer #(.MEM_DEPTH(256), .LINE_COUNT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        logic        full;
        logic        done;
        logic        rdy;
    } wr_t;

    typedef struct {
        logic [7:0]  line;
        logic [15:0] a;
        logic        co;
    } ptr_t;

    // '|' in a table string stands for the NUL terminator.
    typedef struct {
        string       s;
        int          gap;
        int          nwr;
        logic [15:0] d[4];
        logic [7:0]  a[4];
        int          nptr;
        logic [7:0]  pl[2];
        logic [15:0] pa[2];
        logic        pco[2];
    } vec_t;

    wr_t  act_wr[$];
    ptr_t act_ptr[$];
    wr_t  exp_wr[$];
    ptr_t exp_ptr[$];

    int passed = 0;
    int total  = 0;

    always @(negedge clk) begin
        if (bus.wr_en)
            act_wr.push_back('{bus.wr_addr, bus.wr_data, bus.full, bus.done, bus.in_ready});
        if (bus.ptr_wr_en)
            act_ptr.push_back('{bus.ptr_line, bus.ptr_addr,
                                bus.wr_en && (bus.wr_addr == bus.ptr_addr[7:0])});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_strobes"}, {bus.wr_en, bus.ptr_wr_en, bus.full, bus.done, bus.in_ready}, 0);
        chk({name, "_wr"}, {bus.wr_addr, bus.wr_data}, 0);
        chk({name, "_ptr"}, {bus.ptr_line, bus.ptr_addr}, 0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        #1;
        check_zero(name);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        act_wr.delete();
        act_ptr.delete();
        @(negedge clk);
        chk({name, "_ready_after_release"}, bus.in_ready, 1);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge, in_valid still high.
    task automatic send(input logic [7:0] c);
        int   t  = 0;
        logic ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        while (!ok && t < 64) begin
            ok = bus.in_ready;
            @(negedge clk);
            t++;
        end
        if (!ok) begin
            total++;
            $display("FAIL accept_timeout: char %0h not accepted within 64 cycles", c);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gapmax);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = (s[i] == "|") ? 8'h00 : s[i];
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            send(c);
        end
        idle(3);
    endtask

    // Reference: split the stream into NUL-terminated lines, pad each to an even
    // byte count and number the resulting words consecutively from 0.
    task automatic model(input bq_t bytes);
        bq_t cur;
        int  addr     = 0;
        int  line     = 0;
        bit  at_start = 1'b1;
        exp_wr.delete();
        exp_ptr.delete();
        foreach (bytes[i]) begin
            if (at_start) begin
                exp_ptr.push_back('{8'(line), 16'(addr), bytes[i] == 8'h00});
                at_start = 1'b0;
            end
            cur.push_back(bytes[i]);
            if (bytes[i] == 8'h00) begin
                if (cur.size() % 2 != 0) cur.push_back(8'h00);
                for (int k = 0; k < cur.size(); k += 2) begin
                    exp_wr.push_back('{8'(addr), {cur[k], cur[k+1]}, 1'b0, 1'b0, 1'b0});
                    addr++;
                end
                cur.delete();
                line++;
                at_start = 1'b1;
            end
        end
    endtask

    task automatic compare_model(input string name);
        chk({name, "_wr_count"}, act_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
            chk($sformatf("%s_wr%0d", name, i), {act_wr[i].a, act_wr[i].d}, {exp_wr[i].a, exp_wr[i].d});
        chk({name, "_ptr_count"}, act_ptr.size(), exp_ptr.size());
        for (int i = 0; i < exp_ptr.size() && i < act_ptr.size(); i++)
            chk($sformatf("%s_ptr%0d", name, i), {act_ptr[i].line, act_ptr[i].a, act_ptr[i].co},
                {exp_ptr[i].line, exp_ptr[i].a, exp_ptr[i].co});
    endtask

    initial begin
        vec_t vecs[4];
        bq_t  bytes;
        int   accepted;
        string nm;

        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;

        vecs[0] = '{"ab|",     0, 2, '{16'h6162, 16'h0000, 16'h0, 16'h0}, '{8'd0, 8'd1, 8'd0, 8'd0},
                    1, '{8'd0, 8'd0}, '{16'd0, 16'd0}, '{1'b0, 1'b0}};
        vecs[1] = '{"abc|x|",  0, 3, '{16'h6162, 16'h6300, 16'h7800, 16'h0}, '{8'd0, 8'd1, 8'd2, 8'd0},
                    2, '{8'd0, 8'd1}, '{16'd0, 16'd2}, '{1'b0, 1'b0}};
        vecs[2] = '{"|q|",     0, 2, '{16'h0000, 16'h7100, 16'h0, 16'h0}, '{8'd0, 8'd1, 8'd0, 8'd0},
                    2, '{8'd0, 8'd1}, '{16'd0, 16'd1}, '{1'b1, 1'b0}};
        vecs[3] = '{"hello|",  3, 3, '{16'h6865, 16'h6C6C, 16'h6F00, 16'h0}, '{8'd0, 8'd1, 8'd2, 8'd0},
                    1, '{8'd0, 8'd0}, '{16'd0, 16'd0}, '{1'b0, 1'b0}};

        repeat (2) @(negedge clk);
        #1;
        check_zero("reset_state");

        foreach (vecs[v]) begin
            nm = $sformatf("vec%0d", v);
            do_reset(nm);
            send_str(vecs[v].s, vecs[v].gap);
            chk({nm, "_wr_count"}, act_wr.size(), vecs[v].nwr);
            for (int i = 0; i < vecs[v].nwr && i < act_wr.size(); i++)
                chk($sformatf("%s_wr%0d", nm, i), {act_wr[i].a, act_wr[i].d}, {vecs[v].a[i], vecs[v].d[i]});
            chk({nm, "_ptr_count"}, act_ptr.size(), vecs[v].nptr);
            for (int i = 0; i < vecs[v].nptr && i < act_ptr.size(); i++)
                chk($sformatf("%s_ptr%0d", nm, i), {act_ptr[i].line, act_ptr[i].a, act_ptr[i].co},
                    {vecs[v].pl[i], vecs[v].pa[i], vecs[v].pco[i]});
        end

        // Strobe timing relative to the accepting edge, and line counter advance.
        do_reset("lat");
        send(8'h61);
        chk("lat_ptr_after_a", {bus.ptr_wr_en, bus.ptr_line, bus.ptr_addr, bus.wr_en}, {1'b1, 8'd0, 16'd0, 1'b0});
        send(8'h62);
        chk("lat_wr_after_b", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.ptr_wr_en}, {1'b1, 8'd0, 16'h6162, 1'b0});
        send(8'h00);
        chk("lat_wr_after_nul", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 8'd1, 16'h0000});
        send(8'h63);
        chk("lat_next_line_ptr", {bus.ptr_wr_en, bus.ptr_line, bus.ptr_addr}, {1'b1, 8'd1, 16'd2});
        idle(3);

        // Character store exhaustion with in_valid held high throughout.
        do_reset("full");
        accepted     = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 532; i++) begin
            bus.in_char = 8'($urandom_range(1, 255));
            if (bus.in_ready) accepted++;
            @(negedge clk);
        end
        idle(2);
        chk("full_accepted", accepted, 512);
        chk("full_wr_count", act_wr.size(), 256);
        if (act_wr.size() == 256) begin
            chk("full_last_wr", {act_wr[255].a, act_wr[255].full, act_wr[255].rdy, act_wr[255].done},
                {8'd255, 1'b1, 1'b0, 1'b0});
            chk("full_prev_wr", {act_wr[254].a, act_wr[254].full}, {8'd254, 1'b0});
        end
        chk("full_sticky", {bus.full, bus.in_ready}, {1'b1, 1'b0});
        chk("full_ptr_count", act_ptr.size(), 1);

        // Line count exhaustion with empty lines.
        do_reset("done");
        for (int i = 0; i < 64; i++) send(8'h00);
        bus.in_char = 8'h41;
        repeat (5) @(negedge clk);
        idle(2);
        chk("done_wr_count", act_wr.size(), 64);
        if (act_wr.size() == 64) begin
            chk("done_last_wr", {act_wr[63].a, act_wr[63].done, act_wr[63].full, act_wr[63].rdy},
                {8'd63, 1'b1, 1'b0, 1'b0});
            chk("done_prev_wr", act_wr[62].done, 1'b0);
        end
        chk("done_ptr_count", act_ptr.size(), 64);
        if (act_ptr.size() == 64)
            chk("done_last_ptr", {act_ptr[63].line, act_ptr[63].a, act_ptr[63].co}, {8'd63, 16'd63, 1'b1});
        chk("done_sticky", {bus.done, bus.full, bus.in_ready}, {1'b1, 1'b0, 1'b0});

        // Reset after a lone 'a' discards the half-built word.
        do_reset("mid");
        send(8'h61);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_zero("mid_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        act_wr.delete();
        act_ptr.delete();
        @(negedge clk);
        send_str("z|", 0);
        chk("mid_wr_count", act_wr.size(), 1);
        if (act_wr.size() == 1) chk("mid_wr", {act_wr[0].a, act_wr[0].d}, {8'd0, 16'h7A00});
        chk("mid_ptr_count", act_ptr.size(), 1);
        if (act_ptr.size() == 1) chk("mid_ptr", {act_ptr[0].line, act_ptr[0].a}, {8'd0, 16'd0});

        // Randomized lines with random valid gaps against the packing model.
        for (int r = 0; r < 4; r++) begin
            nm = $sformatf("rnd%0d", r);
            do_reset(nm);
            bytes.delete();
            for (int l = $urandom_range(5, 20); l > 0; l--) begin
                for (int c = $urandom_range(0, 9); c > 0; c--) bytes.push_back(8'($urandom_range(1, 127)));
                bytes.push_back(8'h00);
            end
            model(bytes);
            foreach (bytes[i]) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(bytes[i]);
            end
            idle(4);
            compare_model(nm);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ascii_line_packer.md
Name: ascii_line_packer

Overview:
- Write-side counterpart of the packed-ASCII character store and the per-line pointer table.
- Accepts a byte stream of ASCII characters; lines are NUL-terminated (0x00).
- Packs two characters per 16-bit word and emits memory write strobes for the character store.
- Emits one pointer-table entry per line, giving the word address where that line starts, so the readers can later fetch lines by index.

Parameters:
- MEM_DEPTH, 256, number of 16-bit words in the character store; max 256 (8-bit word address).
- LINE_COUNT, 64, number of lines accepted before the block stops; line index is 6 bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_char  input  8  ASCII character; 0x00 marks end of line
- in_valid  input  1  in_char is valid this cycle
- in_ready  output  1  block can accept a character this cycle
- wr_en  output  1  one-cycle pulse: write wr_data to wr_addr
- wr_addr  output  8  character-store word address
- wr_data  output  16  packed word: [15:8] first character, [7:0] second character
- ptr_wr_en  output  1  one-cycle pulse: write ptr_addr to table entry ptr_line
- ptr_line  output  8  line index, {2'b0, idx[5:0]}
- ptr_addr  output  16  start word address of the line, {8'b0, word_addr}
- full  output  1  sticky: character store exhausted
- done  output  1  sticky: LINE_COUNT lines written

Behaviour:
- Reset (async, rst_n=0): all outputs go to 0. Internal word pointer=0, line counter=0, state=LINE_START. in_ready rises to 1 on the first clock after release.
- Handshake:
  - A character is accepted on a rising edge with in_valid=1 and in_ready=1.
  - in_ready = ~full & ~done; it is a registered state, not dependent on in_valid.
  - in_valid gaps of any length are legal.
- States:
  - LINE_START: next character is the high byte and the first character of a new line.
  - HI: next character is the high byte of a word.
  - LO: next character is the low byte; the high byte is latched.
  - STOP: full or done is set; nothing accepted until reset.
- LINE_START, on accept:
  - Register ptr_wr_en=1, ptr_line=line counter, ptr_addr={8'b0, word pointer}.
  - Then handle the character as in HI.
- HI, on accept:
  - Non-NUL character: latch it, go to LO.
  - NUL: emit word {8'h00, 8'h00}, increment line counter, go to LINE_START.
- LO, on accept:
  - Non-NUL character: emit word {latched, char}, go to HI.
  - NUL: emit word {latched, 8'h00}, increment line counter, go to LINE_START.
- Word emission:
  - Registered; wr_en pulses exactly one cycle, the cycle after the accepting edge.
  - wr_addr = word pointer. The word pointer increments after each emit and wraps only through reset.
  - wr_addr, wr_data, ptr_line and ptr_addr hold their last values when their strobe is low.
- NUL handling: the NUL is stored, and lines always start word-aligned.
  - Even-length line: gets a trailing 0x0000 word.
  - Odd-length line: last word's low byte is 0x00.
- Empty line (NUL in LINE_START): ptr_wr_en and wr_en pulse in the same cycle, with ptr_addr = wr_addr.
- Full:
  - When a word is emitted at address MEM_DEPTH-1: full=1 and in_ready=0 in the same cycle as that wr_en, and state becomes STOP.
  - A partially filled line is left unterminated. Software must size the input to fit.
- Done:
  - When the line counter reaches LINE_COUNT after a NUL: done=1 and in_ready=0 together with the final wr_en.
  - If both conditions hit on the same word, full and done are set together.
- Reset mid-line: discards the latched byte and pointers. No wr_en or ptr_wr_en is produced for the partial word.

Test Plan:
- "ab\0" after reset:
  - ptr_wr_en (line 0, addr 0) one cycle after 'a'.
  - wr 0x6162@0, then wr 0x0000@1.
  - Line counter = 1.
- "abc\0" then "x\0" back-to-back, in_valid held high:
  - Writes 0x6162@0, 0x6300@1, 0x7800@2.
  - Pointer entries line0→0, line1→2.
- "\0" as first line: ptr_wr_en and wr_en coincide; line0→0, data 0x0000@0, next line starts at 1.
- Random in_valid gaps on "hello\0":
  - Identical writes to the gap-free case: 0x6865@0, 0x6C6C@1, 0x6F00@2.
  - No extra strobes.
- Feed 512 non-NUL characters with MEM_DEPTH=256:
  - full=1 with wr@255; in_ready=0 afterwards.
  - No further wr_en while in_valid is still asserted.
- Feed 64 lines of "\0": done=1 with wr@63. Then assert rst_n=0 mid-"ab" (after 'a'): all outputs 0, and the next "z\0" writes 0x7A00@0 with ptr line0→0.
